// File: rtl/pulse_stretcher_pkg.sv
// Shared types and sizing helpers for the pulse stretcher indicator block.
package pulse_stretcher_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

  // One down-counter serves both phases, so size it for the longer one.
  function automatic int cnt_width(input int on_cycles, input int off_cycles);
    int m;
    m = (on_cycles > off_cycles) ? on_cycles : off_cycles;
    return (m <= 1) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/pulse_stretcher_if.sv
// Event-in / indicator-out bundle of the pulse stretcher.
interface pulse_stretcher_if #(
  parameter int MAX_PEND = 3
);
  localparam int PW = $clog2(MAX_PEND + 1);

  logic          pulse_in;
  logic          led_out;
  logic          busy;
  logic [PW-1:0] pending;
  logic          overflow;

  modport master (output pulse_in, input led_out, busy, pending, overflow);
  modport slave  (input pulse_in, output led_out, busy, pending, overflow);
endinterface

// File: rtl/pulse_stretcher_sat_counter.sv
// Saturating up/down counter with a sticky overflow flag for dropped increments.
import pulse_stretcher_pkg::*;

module sat_counter #(
  parameter int MAX = 3,
  parameter int W   = $clog2(MAX + 1)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         overflow
);
  localparam logic [W-1:0] TOP = W'(MAX);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count    <= '0;
      overflow <= 1'b0;
    end else if (inc && !dec) begin
      if (count != TOP) count <= count + W'(1);
      else              overflow <= 1'b1;
    end else if (dec && !inc && count != '0) begin
      count <= count - W'(1);
    end
  end
endmodule

// File: rtl/pulse_stretcher.sv
// Stretches single-cycle events into ON_CYCLES high / OFF_CYCLES low periods,
// queueing events that arrive mid-period up to MAX_PEND.
import pulse_stretcher_pkg::*;

module pulse_stretcher #(
  parameter int ON_CYCLES  = 20,
  parameter int OFF_CYCLES = 10,
  parameter int MAX_PEND   = 3
) (
  input  logic               clk,
  input  logic               reset,
  pulse_stretcher_if.slave   io
);
  localparam int CW = cnt_width(ON_CYCLES, OFF_CYCLES);
  localparam int PW = $clog2(MAX_PEND + 1);
  localparam logic [CW-1:0] ON_LOAD  = CW'(ON_CYCLES - 1);
  localparam logic [CW-1:0] OFF_LOAD = CW'(OFF_CYCLES - 1);

  state_e        state;
  logic [CW-1:0] cnt;
  logic [PW-1:0] pending;
  logic          gap_end, pend_inc, pend_dec;

  assign gap_end  = (state == ST_GAP) && (cnt == '0);
  assign pend_dec = gap_end && (pending != '0);
  // At a gap end with nothing queued, a fresh event starts ON directly
  // instead of passing through the queue.
  assign pend_inc = io.pulse_in && (state != ST_IDLE) && !(gap_end && pending == '0);

  sat_counter #(.MAX(MAX_PEND), .W(PW)) u_pend (
    .clk      (clk),
    .reset    (reset),
    .inc      (pend_inc),
    .dec      (pend_dec),
    .count    (pending),
    .overflow (io.overflow)
  );

  assign io.pending = pending;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      io.led_out <= 1'b0;
      io.busy    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (io.pulse_in) begin
            state      <= ST_ON;
            cnt        <= ON_LOAD;
            io.led_out <= 1'b1;
            io.busy    <= 1'b1;
          end
        end
        ST_ON: begin
          io.busy <= 1'b1;
          if (cnt != '0) begin
            cnt <= cnt - CW'(1);
          end else begin
            state      <= ST_GAP;
            cnt        <= OFF_LOAD;
            io.led_out <= 1'b0;
          end
        end
        ST_GAP: begin
          if (cnt != '0) begin
            cnt     <= cnt - CW'(1);
            io.busy <= 1'b1;
          end else if (pending != '0 || io.pulse_in) begin
            state      <= ST_ON;
            cnt        <= ON_LOAD;
            io.led_out <= 1'b1;
            io.busy    <= 1'b1;
          end else begin
            state   <= ST_IDLE;
            io.busy <= 1'b0;
          end
        end
        default: begin
          state      <= ST_IDLE;
          cnt        <= '0;
          io.led_out <= 1'b0;
          io.busy    <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_pulse_stretcher.sv
// Scoreboard bench: stimulus queues hand-computed per-edge expectations,
// a monitor pops and compares them just after each rising edge.
module tb_pulse_stretcher;
  localparam int ON = 4, OFF = 2, MP = 2;
  localparam int PW = $clog2(MP + 1);

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  pulse_stretcher_if #(.MAX_PEND(MP)) io();

  pulse_stretcher #(.ON_CYCLES(ON), .OFF_CYCLES(OFF), .MAX_PEND(MP)) dut (
    .clk   (clk),
    .reset (reset),
    .io    (io)
  );

  typedef struct {
    string         tag;
    int            cyc;
    logic          led;
    logic          busy;
    logic [PW-1:0] pend;
    logic          ovf;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (q.size() != 0) begin
      mon_e = q.pop_front();
      chk($sformatf("%s[E%0d].led",  mon_e.tag, mon_e.cyc), 32'(io.led_out),  32'(mon_e.led));
      chk($sformatf("%s[E%0d].busy", mon_e.tag, mon_e.cyc), 32'(io.busy),     32'(mon_e.busy));
      chk($sformatf("%s[E%0d].pend", mon_e.tag, mon_e.cyc), 32'(io.pending),  32'(mon_e.pend));
      chk($sformatf("%s[E%0d].ovf",  mon_e.tag, mon_e.cyc), 32'(io.overflow), 32'(mon_e.ovf));
    end
  end

  // Character i of each string is the pulse sampled at edge Ei and the
  // outputs expected just after Ei.
  task automatic run_vec(input string tag, input string pul, input string led,
                         input string bsy, input string pnd, input string ovf);
    exp_t e;
    for (int i = 0; i < pul.len(); i++) begin
      @(negedge clk);
      io.pulse_in = (pul[i] == 8'h31);
      e.tag  = tag;
      e.cyc  = i;
      e.led  = (led[i] == 8'h31);
      e.busy = (bsy[i] == 8'h31);
      e.pend = PW'(pnd[i] - 8'h30);
      e.ovf  = (ovf[i] == 8'h31);
      q.push_back(e);
    end
    @(negedge clk);
    io.pulse_in = 1'b0;
    chk({tag, ".drain"}, 32'(q.size()), 32'd0);
  endtask

  // Reset is raised between edges; outputs must clear with no clock.
  task automatic async_reset(input string tag);
    @(negedge clk);
    io.pulse_in = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk({tag, ".led"},  32'(io.led_out),  32'd0);
    chk({tag, ".busy"}, 32'(io.busy),     32'd0);
    chk({tag, ".pend"}, 32'(io.pending),  32'd0);
    chk({tag, ".ovf"},  32'(io.overflow), 32'd0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, expected done", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    io.pulse_in = 1'b0;
    repeat (2) @(negedge clk);

    async_reset("t1_rst");
    run_vec("t1_single", "10000000", "11110000", "11111100", "00000000", "00000000");

    async_reset("t2_rst");
    run_vec("t2_queue1", "1010000000000", "1111001111000", "1111111111110",
            "0011110000000", "0000000000000");

    async_reset("t3_rst");
    run_vec("t3_sat", "1111000000000000000", "1111001111001111000",
            "1111111111111111110", "0122221111110000000", "0001111111111111111");

    async_reset("t4_rst");
    run_vec("t4_gapend", "1000001000000", "1111001111000", "1111111111110",
            "0000000000000", "0000000000000");

    async_reset("t5_rst");
    run_vec("t5_incdec", "1010001000000000000", "1111001111001111000",
            "1111111111111111110", "0011111111110000000", "0000000000000000000");

    async_reset("t6_rst0");
    run_vec("t6_pre", "11100000", "11110011", "11111111", "01222211", "00000000");
    async_reset("t6_midon");
    run_vec("t6_after", "10000000", "11110000", "11111100", "00000000", "00000000");

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
